// File: rtl/hit_bitmap_reader.sv
// hit_bitmap_reader: scans the hit bitmap RAM row by row through one RAM port and
// streams one (row, letter) pair per set bit, optionally zeroing each row behind the scan.
module hit_bitmap_reader #(
  parameter int WORDLENGTH   = 16,
  parameter int MEMNROWS     = 16,
  parameter int ROWINDEXBITS = 4,
  parameter int COLINDEXBITS = 4,
  parameter int COUNTBITS    = ROWINDEXBITS + COLINDEXBITS + 1
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    startRead,
  input  logic                    clearOnRead,
  output logic                    busy,
  output logic                    readDone,
  output logic [COUNTBITS-1:0]    hitCount,
  output logic [ROWINDEXBITS-1:0] memAddress,
  output logic                    memWriteEnable,
  output logic [WORDLENGTH-1:0]   memWriteData,
  input  logic [WORDLENGTH-1:0]   memData,
  output logic                    hitValid,
  input  logic                    hitReady,
  output logic [ROWINDEXBITS-1:0] hitWordIndex,
  output logic [COLINDEXBITS-1:0] hitLetterIndex
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ROWINDEXBITS-1:0] LAST_ROW  = ROWINDEXBITS'(MEMNROWS - 1);
  localparam logic [ROWINDEXBITS-1:0] ONE_ROW   = {{(ROWINDEXBITS-1){1'b0}}, 1'b1};
  localparam logic [WORDLENGTH-1:0]   ONE_WORD  = {{(WORDLENGTH-1){1'b0}}, 1'b1};
  localparam logic [WORDLENGTH-1:0]   ZERO_WORD = {WORDLENGTH{1'b0}};
  localparam logic [COUNTBITS-1:0]    ONE_COUNT = {{(COUNTBITS-1){1'b0}}, 1'b1};
  localparam logic [COUNTBITS-1:0]    COUNT_MAX = {COUNTBITS{1'b1}};

  // Index of the lowest set bit; the downward loop lets the lowest bit win.
  function automatic logic [COLINDEXBITS-1:0] lowest_set(input logic [WORDLENGTH-1:0] bits);
    logic [COLINDEXBITS-1:0] idx;
    idx = {COLINDEXBITS{1'b0}};
    for (int i = WORDLENGTH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = COLINDEXBITS'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t                  state_q, state_d;
  logic [ROWINDEXBITS-1:0] row_index_q, row_index_d;
  logic [WORDLENGTH-1:0]   row_bits_q, row_bits_d;
  logic                    clear_mode_q, clear_mode_d;
  logic [COUNTBITS-1:0]    hit_count_q, hit_count_d;
  logic                    busy_q, busy_d;
  logic                    read_done_q, read_done_d;
  logic [ROWINDEXBITS-1:0] mem_address_q, mem_address_d;
  logic                    mem_we_q, mem_we_d;
  logic                    hit_valid_q, hit_valid_d;
  logic [ROWINDEXBITS-1:0] hit_word_q, hit_word_d;
  logic [COLINDEXBITS-1:0] hit_letter_q, hit_letter_d;

  logic [WORDLENGTH-1:0]   remaining_s;
  logic                    last_row_s;
  logic [ROWINDEXBITS-1:0] next_row_s;
  state_t                  after_row_state_s;

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d       = state_q;
    row_index_d   = row_index_q;
    row_bits_d    = row_bits_q;
    clear_mode_d  = clear_mode_q;
    hit_count_d   = hit_count_q;
    busy_d        = busy_q;
    read_done_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_we_d      = 1'b0;
    hit_valid_d   = hit_valid_q;
    hit_word_d    = hit_word_q;
    hit_letter_d  = hit_letter_q;

    remaining_s       = row_bits_q & (row_bits_q - ONE_WORD);
    last_row_s        = (row_index_q == LAST_ROW);
    next_row_s        = last_row_s ? row_index_q : (row_index_q + ONE_ROW);
    after_row_state_s = last_row_s ? S_DONE : S_READ;

    case (state_q)
      S_IDLE: begin
        if (startRead) begin
          state_d       = S_READ;
          row_index_d   = {ROWINDEXBITS{1'b0}};
          hit_count_d   = {COUNTBITS{1'b0}};
          clear_mode_d  = clearOnRead;
          busy_d        = 1'b1;
          mem_address_d = {ROWINDEXBITS{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d  = S_LATCH;
        // The zero write is presented during LATCH, after the read was already captured.
        mem_we_d = clear_mode_q;
      end
      S_LATCH: begin
        row_bits_d = memData;
        if (memData != ZERO_WORD) begin
          state_d      = S_EMIT;
          hit_valid_d  = 1'b1;
          hit_word_d   = row_index_q;
          hit_letter_d = lowest_set(memData);
        end else begin
          state_d       = after_row_state_s;
          busy_d        = !last_row_s;
          read_done_d   = last_row_s;
          row_index_d   = next_row_s;
          mem_address_d = next_row_s;
        end
      end
      S_EMIT: begin
        if (hit_valid_q && hitReady) begin
          row_bits_d  = remaining_s;
          hit_count_d = (hit_count_q != COUNT_MAX) ? (hit_count_q + ONE_COUNT) : hit_count_q;
          if (remaining_s != ZERO_WORD) begin
            hit_letter_d = lowest_set(remaining_s);
          end else begin
            hit_valid_d   = 1'b0;
            state_d       = after_row_state_s;
            busy_d        = !last_row_s;
            read_done_d   = last_row_s;
            row_index_d   = next_row_s;
            mem_address_d = next_row_s;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        hit_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset forces every strobe low immediately.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      row_index_q   <= {ROWINDEXBITS{1'b0}};
      row_bits_q    <= {WORDLENGTH{1'b0}};
      clear_mode_q  <= 1'b0;
      hit_count_q   <= {COUNTBITS{1'b0}};
      busy_q        <= 1'b0;
      read_done_q   <= 1'b0;
      mem_address_q <= {ROWINDEXBITS{1'b0}};
      mem_we_q      <= 1'b0;
      hit_valid_q   <= 1'b0;
      hit_word_q    <= {ROWINDEXBITS{1'b0}};
      hit_letter_q  <= {COLINDEXBITS{1'b0}};
    end else begin
      state_q       <= state_d;
      row_index_q   <= row_index_d;
      row_bits_q    <= row_bits_d;
      clear_mode_q  <= clear_mode_d;
      hit_count_q   <= hit_count_d;
      busy_q        <= busy_d;
      read_done_q   <= read_done_d;
      mem_address_q <= mem_address_d;
      mem_we_q      <= mem_we_d;
      hit_valid_q   <= hit_valid_d;
      hit_word_q    <= hit_word_d;
      hit_letter_q  <= hit_letter_d;
    end
  end

  assign busy           = busy_q;
  assign readDone       = read_done_q;
  assign hitCount       = hit_count_q;
  assign memAddress     = mem_address_q;
  assign memWriteEnable = mem_we_q;
  assign memWriteData   = {WORDLENGTH{1'b0}};
  assign hitValid       = hit_valid_q;
  assign hitWordIndex   = hit_word_q;
  assign hitLetterIndex = hit_letter_q;

endmodule

// File: tb/tb_hit_bitmap_reader.sv
// Self-checking bench for hit_bitmap_reader: a RAM model plus a behavioural
// reference that lists hits row-major, lowest bit first, and predicts scan length.
module tb_hit_bitmap_reader;
  localparam int W   = 16;
  localparam int N   = 16;
  localparam int RB  = 4;
  localparam int CB  = 4;
  localparam int CNT = RB + CB + 1;

  logic          clock = 1'b0;
  logic          resetN = 1'b1;
  logic          startRead = 1'b0;
  logic          clearOnRead = 1'b0;
  logic          hitReady = 1'b0;
  logic          busy, readDone, memWriteEnable, hitValid;
  logic [CNT-1:0] hitCount;
  logic [RB-1:0] memAddress, hitWordIndex;
  logic [CB-1:0] hitLetterIndex;
  logic [W-1:0]  memWriteData, memData;

  logic [W-1:0]  mem [N];
  logic [W-1:0]  img [N];
  logic          tb_load = 1'b0;
  logic [RB-1:0] tb_addr = '0;
  logic [W-1:0]  tb_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  bit   active = 1'b0;
  int   cyc, total, accepted, stalls;
  int   exp_q[$];
  int   log_q[$];
  bit   prev_stall = 1'b0;
  logic [RB+CB-1:0] prev_fields;

  hit_bitmap_reader dut (
    .clock(clock), .resetN(resetN), .startRead(startRead), .clearOnRead(clearOnRead),
    .busy(busy), .readDone(readDone), .hitCount(hitCount), .memAddress(memAddress),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memData(memData),
    .hitValid(hitValid), .hitReady(hitReady), .hitWordIndex(hitWordIndex),
    .hitLetterIndex(hitLetterIndex)
  );

  always #5 clock = ~clock;

  // Registered-read RAM; the bench loads it through its own port.
  always @(posedge clock) begin
    if (tb_load) mem[tb_addr] <= tb_data;
    else if (memWriteEnable) mem[memAddress] <= memWriteData;
    memData <= mem[memAddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Compare process: checks outputs mid-cycle and advances the reference model.
  always @(negedge clock or negedge resetN) begin
    bit was_active;
    bit exp_done;
    if (!resetN) begin
      active = 1'b0;
      prev_stall = 1'b0;
    end else begin
      was_active = active;
      if (active) begin
        cyc++;
        exp_done = (accepted == total) && (cyc == 2 * N + 1 + total + stalls);
        check("readDone", readDone, exp_done);
        check("busy", busy, !exp_done);
        if (prev_stall) begin
          check("stall_valid", hitValid, 1);
          check("stall_fields", {hitWordIndex, hitLetterIndex}, prev_fields);
        end
        if (hitValid) begin
          check("hit_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("hit_fields", {hitWordIndex, hitLetterIndex}, exp_q[0]);
          check("hit_count_running", hitCount, accepted);
        end
        if (exp_done) begin
          check("final_hitCount", hitCount, total);
          check("done_no_hit", hitValid, 0);
          active = 1'b0;
        end
        prev_stall  = hitValid && !hitReady;
        prev_fields = {hitWordIndex, hitLetterIndex};
        if (hitValid && hitReady) begin
          accepted++;
          log_q.push_back(int'({hitWordIndex, hitLetterIndex}));
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (hitValid) begin
          stalls++;
        end
      end else begin
        check("idle_quiet", {busy, readDone, hitValid, memWriteEnable}, 0);
        prev_stall = 1'b0;
      end
      if (!was_active && startRead) begin
        active = 1'b1;
        cyc = 0; accepted = 0; stalls = 0;
        exp_q.delete();
        log_q.delete();
        for (int r = 0; r < N; r++)
          for (int b = 0; b < W; b++)
            if (mem[r][b]) exp_q.push_back(r * (1 << CB) + b);
        total = exp_q.size();
      end
    end
  end

  task automatic load_img;
    for (int r = 0; r < N; r++) begin
      tb_load = 1'b1; tb_addr = RB'(r); tb_data = img[r];
      tick;
    end
    tb_load = 1'b0;
    tick;
  endtask

  task automatic clear_img;
    for (int r = 0; r < N; r++) img[r] = '0;
  endtask

  // mode 0: hitReady high, 1: toggling, 2: random. poke>0 pulses startRead while busy.
  task automatic run_scan(input bit clr, input int mode, input int poke, output int done_cyc);
    int n;
    clearOnRead = clr;
    hitReady = (mode == 0);
    startRead = 1'b1;
    tick;
    startRead = 1'b0;
    n = 1;
    while (!readDone && n < 400) begin
      startRead = (n == poke);
      clearOnRead = 1'($urandom_range(0, 1));
      case (mode)
        0: hitReady = 1'b1;
        1: hitReady = n[0];
        default: hitReady = ($urandom_range(0, 3) != 0);
      endcase
      tick;
      n++;
    end
    startRead = 1'b0;
    check("done_within_bound", readDone, 1);
    done_cyc = n;
    tick;
  endtask

  initial begin
    int d;
    int saved[$];
    int ones;
    int pulses;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int saved[$];
    int ones;
    int pulses;
    #1 resetN = 1'b0;
    #1 check("reset_outputs", {busy, readDone, hitValid, memWriteEnable, hitCount,
                               memAddress, hitWordIndex, hitLetterIndex}, 0);
    @(posedge clock); @(posedge clock); #1 resetN = 1'b1;
    tick;

    // All-zero memory
    clear_img; load_img;
    run_scan(1'b0, 0, 0, d);
    check("empty_done_cycle", d, 33);
    check("empty_hitCount", hitCount, 0);

    // Row 3 = 0x0021
    clear_img; img[3] = 16'h0021; load_img;
    run_scan(1'b0, 0, 0, d);
    check("row3_done_cycle", d, 35);
    check("row3_nhits", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("row3_hit0", log_q[0], 3 * 16 + 0);
      check("row3_hit1", log_q[1], 3 * 16 + 5);
    end

    // Row 15 full with hitReady toggling
    clear_img; img[15] = 16'hFFFF; load_img;
    run_scan(1'b0, 1, 0, d);
    check("row15_hitCount", hitCount, 16);
    check("row15_nhits", log_q.size(), 16);
    for (int i = 0; i < log_q.size(); i++) check("row15_order", log_q[i], 15 * 16 + i);

    // Rows 0 and 7 with clear-on-read
    clear_img; img[0] = 16'h8001; img[7] = 16'h0F00; load_img;
    run_scan(1'b1, 2, 0, d);
    check("clear_hitCount", hitCount, 6);
    for (int r = 0; r < N; r++) check("clear_row_zero", mem[r], 0);
    run_scan(1'b0, 0, 0, d);
    check("clear_second_hitCount", hitCount, 0);

    // Same setup without clearing: memory kept, sequence repeats
    load_img;
    run_scan(1'b0, 2, 0, d);
    saved = log_q;
    check("keep_nhits", saved.size(), 6);
    if (saved.size() == 6) begin
      check("keep_hit0", saved[0], 0);
      check("keep_hit1", saved[1], 15);
      check("keep_hit2", saved[2], 7 * 16 + 8);
    end
    for (int r = 0; r < N; r++) check("keep_row", mem[r], img[r]);
    run_scan(1'b0, 2, 0, d);
    check("repeat_nhits", log_q.size(), saved.size());
    for (int i = 0; i < log_q.size() && i < saved.size(); i++) check("repeat_hit", log_q[i], saved[i]);

    // Randomized scans
    for (int t = 0; t < 6; t++) begin
      bit clr;
      clr = 1'($urandom_range(0, 1));
      for (int r = 0; r < N; r++) img[r] = W'($urandom & $urandom & $urandom);
      load_img;
      run_scan(clr, 2, 10, d);
      for (int r = 0; r < N; r++) check("rand_mem", mem[r], clr ? '0 : img[r]);
    end

    // Reset while emitting row 7 during a clearing scan
    clear_img; img[7] = 16'h0011;
    for (int r = 8; r < N; r++) img[r] = W'($urandom) | 16'h0001;
    load_img;
    clearOnRead = 1'b1; hitReady = 1'b0; startRead = 1'b1;
    tick;
    startRead = 1'b0;
    for (int i = 0; i < 100 && !hitValid; i++) tick;
    check("reach_row7", {hitValid, hitWordIndex}, {1'b1, 4'd7});
    resetN = 1'b0;
    #1 check("midscan_reset_outputs", {busy, readDone, hitValid, memWriteEnable, hitCount,
                                       memAddress, hitWordIndex, hitLetterIndex}, 0);
    for (int r = 0; r < 8; r++) check("reset_cleared_rows", mem[r], 0);
    for (int r = 8; r < N; r++) check("reset_untouched_rows", mem[r], img[r]);
    @(posedge clock); #1 resetN = 1'b1;
    tick;
    ones = 0;
    for (int r = 8; r < N; r++) ones += $countones(img[r]);
    run_scan(1'b0, 0, 5, d);
    check("post_reset_hitCount", hitCount, ones);
    check("post_reset_done_cycle", d, 33 + ones);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (readDone) pulses++;
      tick;
    end
    check("no_second_done", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_bitmap_reader.md
# hit_bitmap_reader

Read-side companion to the hit bitmap storage. On request, it scans every row of the hit bitmap block RAM through one RAM port and priority-encodes the set bits. It emits one (wordIndex, letterIndex) hit per accepted handshake, and can optionally zero each row after reading it so the next event starts from an empty bitmap. It sits between the bitmap RAM's read port and downstream hit consumers (track/pattern logic).

## Interface
- WORDLENGTH, 16, bits per RAM row (one bit per letter)
- MEMNROWS, 16, number of RAM rows
- ROWINDEXBITS, 4, row address width
- COLINDEXBITS, 4, letter index width, with 2^COLINDEXBITS >= WORDLENGTH
- COUNTBITS, ROWINDEXBITS+COLINDEXBITS+1, hit counter width

- clock  in  1  single clock; all logic on posedge
- resetN  in  1  asynchronous, active-low reset
- startRead  in  1  request a full scan; sampled only in IDLE
- clearOnRead  in  1  latched at start; 1 = zero each row after it is read
- busy  out  1  high from the cycle after start is accepted until DONE
- readDone  out  1  one-cycle pulse when the scan completes
- hitCount  out  COUNTBITS  hits emitted in the current/last scan; holds after DONE
- memAddress  out  ROWINDEXBITS  RAM port address
- memWriteEnable  out  1  RAM port write enable (clear)
- memWriteData  out  WORDLENGTH  always 0
- memData  in  WORDLENGTH  RAM port read data; registered, valid 1 cycle after address
- hitValid  out  1  hit output valid
- hitReady  in  1  downstream accepts hit
- hitWordIndex  out  ROWINDEXBITS  row of current hit
- hitLetterIndex  out  COLINDEXBITS  bit position of current hit

## Operation
- States: IDLE, READ, LATCH, EMIT, DONE.
- IDLE: all strobes low. On startRead=1:
  - rowIndex<=0
  - hitCount<=0
  - clearMode<=clearOnRead
  - go to READ
- READ: memAddress=rowIndex, memWriteEnable=0. Go to LATCH.
- LATCH: memData is valid.
  - rowBits<=memData.
  - If clearMode: memWriteEnable=1 and memAddress=rowIndex in this cycle. The zero write lands at this edge. The captured data is unaffected because it was registered at the previous edge.
  - If memData!=0, go to EMIT.
  - Else if rowIndex==MEMNROWS-1, go to DONE.
  - Else rowIndex<=rowIndex+1 and go to READ.
- EMIT: hitValid=1, hitWordIndex=rowIndex, hitLetterIndex = index of the lowest set bit of rowBits.
  - On hitValid&&hitReady: clear that bit in rowBits and increment hitCount.
  - If that was the last set bit, leave EMIT by the same rules as an empty LATCH (DONE or next READ).
- DONE: readDone=1 for one cycle, then IDLE.
- Outputs are registered. hitWordIndex and hitLetterIndex are stable while hitValid=1 and hitReady=0.
- Bits at positions >= WORDLENGTH do not exist. Bit order is lowest letter first; row order is 0 upward.
- startRead while busy is ignored. It is neither queued nor allowed to restart the scan.
- clearOnRead changes mid-scan have no effect.
- hitCount saturates at 2^COUNTBITS-1. This value is unreachable with the default parameters.

## Timing
- Reset values: state=IDLE, busy=0, readDone=0, hitValid=0, hitCount=0, memAddress=0, memWriteEnable=0, hitWordIndex=0, hitLetterIndex=0.
- startRead sampled at edge k: busy=1 and READ in the cycle after k. The first row's data is in LATCH one cycle later.
- Empty row costs 2 cycles (READ+LATCH).
- A row with n hits and hitReady held high costs 2+n cycles.
  - First hitValid appears 3 cycles after the start edge for row 0.
  - Back-to-back hits within a row arrive on consecutive cycles.
- Fully empty memory: readDone pulses 2*MEMNROWS+1 cycles after the start edge. With defaults, that is cycle 33.
- busy drops in the same cycle readDone is high (DONE state has busy=0).
- A new startRead is accepted in the IDLE cycle after DONE.
- resetN asserted mid-scan:
  - Immediate return to IDLE.
  - hitValid and memWriteEnable drop asynchronously.
  - An interrupted clear leaves the remaining rows unmodified.

## Test plan
- All-zero RAM, startRead, hitReady=1 -> no hitValid; readDone exactly 33 cycles after start; hitCount=0; busy high for cycles 1..32.
- RAM row 3 = 0x0021, others 0, hitReady=1 -> hits (3,0) then (3,5) on consecutive cycles; hitCount=2; readDone at cycle 35.
- Row 15 = 0xFFFF with hitReady toggling every other cycle -> 16 hits (15,0)..(15,15) in order; fields stable while stalled; hitCount=16.
- Rows 0 and 7 nonzero, clearOnRead=1 -> hits emitted; RAM read back afterwards is all zero; second scan returns hitCount=0.
- Same setup with clearOnRead=0 -> RAM unchanged after scan; second scan repeats identical hit sequence.
- Assert resetN during EMIT of row 7 with clearOnRead=1 -> outputs at reset values immediately; rows 8..15 unmodified; startRead after release runs a full scan; startRead pulsed during busy -> ignored, single readDone.
